// File: rtl/uivbuf_wr_seq_if.sv
// rtl/uivbuf_wr_seq_if.sv - frame event / buffer index bundle between video writer and write sequencer
interface uivbuf_wr_seq_if #(
    parameter int CNT_W = 16
);
    logic             I_fs;
    logic             I_fe;
    logic [7:0]       I_rd_bufn;
    logic [7:0]       O_bufn;
    logic [7:0]       O_done_bufn;
    logic             O_done_vld;
    logic             O_busy;
    logic [CNT_W-1:0] O_frame_cnt;
    logic [CNT_W-1:0] O_err_cnt;
    logic             O_err;

    modport master (
        output I_fs, I_fe, I_rd_bufn,
        input  O_bufn, O_done_bufn, O_done_vld, O_busy, O_frame_cnt, O_err_cnt, O_err
    );

    modport slave (
        input  I_fs, I_fe, I_rd_bufn,
        output O_bufn, O_done_bufn, O_done_vld, O_busy, O_frame_cnt, O_err_cnt, O_err
    );
endinterface

// File: rtl/uivbuf_wr_seq.sv
// rtl/uivbuf_wr_seq.sv - write-side buffer index sequencer for the multi-frame VDMA ring
module uivbuf_wr_seq #(
    parameter int BUF_LENTH = 3,
    parameter int AVOID_RD  = 1,
    parameter int CNT_W     = 16
) (
    input  logic             I_clk,
    input  logic             I_rstn,
    uivbuf_wr_seq_if.slave   bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [7:0]       LEN      = 8'(BUF_LENTH);
    localparam bit               AVOID_EN = (AVOID_RD != 0) && (BUF_LENTH >= 3);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [1:0]       state;
    logic [7:0]       bufn;
    logic [7:0]       done_bufn;
    logic             done_vld;
    logic             err;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [7:0]       n1;
    logic [7:0]       n2;
    logic [7:0]       nxt;

    // Skipping the reader's buffer needs at least three slots, otherwise the
    // writer would land back on the buffer it just finished.
    always_comb begin
        n1  = (bufn + 8'd1 == LEN) ? 8'd0 : bufn + 8'd1;
        n2  = (n1 + 8'd1 == LEN) ? 8'd0 : n1 + 8'd1;
        nxt = (AVOID_EN && (n1 == bus.I_rd_bufn)) ? n2 : n1;
    end

    always_ff @(posedge I_clk or negedge I_rstn) begin
        if (!I_rstn) begin
            state     <= S_IDLE;
            bufn      <= 8'd0;
            done_bufn <= 8'd0;
            done_vld  <= 1'b0;
            err       <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            done_vld <= 1'b0;
            err      <= 1'b0;
            case (state)
                S_IDLE, S_WAIT: begin
                    if (bus.I_fs) begin
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (bus.I_fe) begin
                        // Simultaneous start is taken as end-then-start on the new index.
                        done_bufn <= bufn;
                        done_vld  <= 1'b1;
                        frame_cnt <= frame_cnt + CNT_ONE;
                        bufn      <= nxt;
                        state     <= bus.I_fs ? S_WRITE : S_WAIT;
                    end else if (bus.I_fs) begin
                        err <= 1'b1;
                        if (err_cnt != CNT_MAX) begin
                            err_cnt <= err_cnt + CNT_ONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.O_bufn      = bufn;
    assign bus.O_done_bufn = done_bufn;
    assign bus.O_done_vld  = done_vld;
    assign bus.O_busy      = (state == S_WRITE);
    assign bus.O_frame_cnt = frame_cnt;
    assign bus.O_err_cnt   = err_cnt;
    assign bus.O_err       = err;
endmodule

// File: tb/tb_uivbuf_wr_seq.sv
// tb/tb_uivbuf_wr_seq.sv - self-checking bench for uivbuf_wr_seq
module tb_uivbuf_wr_seq;
    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] rd;

    always #5 clk = ~clk;

    uivbuf_wr_seq_if #(.CNT_W(16)) ia ();
    uivbuf_wr_seq_if #(.CNT_W(3))  ib ();

    uivbuf_wr_seq #(.BUF_LENTH(3), .AVOID_RD(1), .CNT_W(16)) dut_a (
        .I_clk (clk),
        .I_rstn(rstn),
        .bus   (ia.slave)
    );

    uivbuf_wr_seq #(.BUF_LENTH(2), .AVOID_RD(1), .CNT_W(3)) dut_b (
        .I_clk (clk),
        .I_rstn(rstn),
        .bus   (ib.slave)
    );

    assign ia.I_rd_bufn = rd;
    assign ib.I_rd_bufn = rd;

    int n_pass  = 0;
    int n_total = 0;
    int vld_seen_a = 0;

    // Reference model, index 0 = ring of 3 with 16-bit counters, 1 = ring of 2 with 3-bit counters
    int lenv[2] = '{3, 2};
    int cmod[2] = '{65536, 8};
    int m_buf[2], m_done[2], m_vld[2], m_cnt[2], m_ecnt[2], m_err[2];
    bit m_in[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int next_idx(input int d, input int cur, input int rdv);
        int c;
        c = (cur + 1) % lenv[d];
        if (lenv[d] >= 3 && c == rdv) c = (c + 1) % lenv[d];
        return c;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_buf[d] = 0; m_done[d] = 0; m_vld[d] = 0;
            m_cnt[d] = 0; m_ecnt[d] = 0; m_err[d] = 0; m_in[d] = 0;
        end
    endtask

    task automatic model_step(input bit fs, input bit fe, input int rdv);
        for (int d = 0; d < 2; d++) begin
            m_vld[d] = 0;
            m_err[d] = 0;
            if (m_in[d]) begin
                if (fe) begin
                    m_done[d] = m_buf[d];
                    m_vld[d]  = 1;
                    m_cnt[d]  = (m_cnt[d] + 1) % cmod[d];
                    m_buf[d]  = next_idx(d, m_buf[d], rdv);
                    m_in[d]   = fs;
                end else if (fs) begin
                    m_err[d] = 1;
                    if (m_ecnt[d] < cmod[d] - 1) m_ecnt[d]++;
                end
            end else if (fs) begin
                m_in[d] = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("a_bufn",      32'(ia.O_bufn),      m_buf[0]);
        chk("a_done_bufn", 32'(ia.O_done_bufn), m_done[0]);
        chk("a_done_vld",  32'(ia.O_done_vld),  m_vld[0]);
        chk("a_busy",      32'(ia.O_busy),      32'(m_in[0]));
        chk("a_frame_cnt", 32'(ia.O_frame_cnt), m_cnt[0]);
        chk("a_err_cnt",   32'(ia.O_err_cnt),   m_ecnt[0]);
        chk("a_err",       32'(ia.O_err),       m_err[0]);
        chk("b_bufn",      32'(ib.O_bufn),      m_buf[1]);
        chk("b_done_bufn", 32'(ib.O_done_bufn), m_done[1]);
        chk("b_done_vld",  32'(ib.O_done_vld),  m_vld[1]);
        chk("b_busy",      32'(ib.O_busy),      32'(m_in[1]));
        chk("b_frame_cnt", 32'(ib.O_frame_cnt), m_cnt[1]);
        chk("b_err_cnt",   32'(ib.O_err_cnt),   m_ecnt[1]);
        chk("b_err",       32'(ib.O_err),       m_err[1]);
    endtask

    task automatic step(input bit fs, input bit fe);
        int rdv;
        rdv = int'(rd);
        ia.I_fs = fs; ia.I_fe = fe;
        ib.I_fs = fs; ib.I_fe = fe;
        @(posedge clk);
        #1;
        ia.I_fs = 1'b0; ia.I_fe = 1'b0;
        ib.I_fs = 1'b0; ib.I_fe = 1'b0;
        model_step(fs, fe, rdv);
        if (ia.O_done_vld === 1'b1) vld_seen_a++;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    // Reset is asserted between clock edges and checked before the next edge.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #2;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    int exp_done[4] = '{0, 1, 2, 0};
    int exp_buf[4]  = '{1, 2, 0, 1};

    initial begin
        rstn = 1'b0;
        rd   = 8'd7;
        ia.I_fs = 1'b0; ia.I_fe = 1'b0;
        ib.I_fs = 1'b0; ib.I_fe = 1'b0;
        model_reset();
        do_reset();

        // Four clean frames, reader index out of range
        vld_seen_a = 0;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0);
            idle(10);
            step(1'b0, 1'b1);
            chk("seq_done_bufn", 32'(ia.O_done_bufn), exp_done[k]);
            chk("seq_bufn",      32'(ia.O_bufn),      exp_buf[k]);
        end
        chk("seq_frame_cnt", 32'(ia.O_frame_cnt), 4);
        chk("seq_vld_pulses", vld_seen_a, 4);

        // Reader avoidance, and its suppression on a 2-buffer ring
        do_reset();
        rd = 8'd1;
        step(1'b1, 1'b0); idle(3); step(1'b0, 1'b1);
        chk("avoid_skip_a", 32'(ia.O_bufn), 2);
        chk("avoid_off_b",  32'(ib.O_bufn), 1);
        rd = 8'd0;
        step(1'b1, 1'b0); idle(3); step(1'b0, 1'b1);
        chk("avoid_wrap_a", 32'(ia.O_bufn), 1);

        // Abort: second start without an end
        do_reset();
        rd = 8'd7;
        step(1'b1, 1'b0); idle(5); step(1'b1, 1'b0);
        chk("abort_err",     32'(ia.O_err),     1);
        chk("abort_err_cnt", 32'(ia.O_err_cnt), 1);
        chk("abort_bufn",    32'(ia.O_bufn),    0);
        chk("abort_busy",    32'(ia.O_busy),    1);
        step(1'b0, 1'b1);
        chk("abort_done_bufn", 32'(ia.O_done_bufn), 0);
        chk("abort_next_bufn", 32'(ia.O_bufn),      1);

        // Simultaneous end+start on buffer 1, then stray end while waiting
        step(1'b1, 1'b0); idle(3); step(1'b1, 1'b1);
        chk("both_done_bufn", 32'(ia.O_done_bufn), 1);
        chk("both_bufn",      32'(ia.O_bufn),      2);
        chk("both_busy",      32'(ia.O_busy),      1);
        chk("both_err",       32'(ia.O_err),       0);
        idle(2); step(1'b0, 1'b1);
        idle(1); step(1'b0, 1'b1);
        chk("stray_bufn",      32'(ia.O_bufn),      0);
        chk("stray_frame_cnt", 32'(ia.O_frame_cnt), 3);

        // Error counter saturation on the 3-bit instance
        step(1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
        chk("sat_b_err_cnt", 32'(ib.O_err_cnt), 7);
        chk("sat_a_err_cnt", 32'(ia.O_err_cnt), 10);
        step(1'b0, 1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rd = 8'($urandom_range(0, 9));
            step($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15);
        end

        // Reset in the middle of a frame on buffer 2 after five frames
        do_reset();
        rd = 8'd7;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0); idle(2); step(1'b0, 1'b1);
        end
        step(1'b1, 1'b0); idle(3);
        chk("pre_rst_bufn", 32'(ia.O_bufn),      2);
        chk("pre_rst_cnt",  32'(ia.O_frame_cnt), 5);
        do_reset();
        step(1'b1, 1'b0); idle(2); step(1'b0, 1'b1);
        chk("post_rst_done_bufn", 32'(ia.O_done_bufn), 0);
        chk("post_rst_bufn",      32'(ia.O_bufn),      1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
